// File: rtl/apb_mem_slave.sv
// APB completer backed by a depth-word register memory, with configurable wait states and byte-strobed writes.
// Define APB_MEM_SLAVE_PSLVERR_EN to flag out-of-range and empty-strobe accesses on pslverr.
module apb_mem_slave #(
    parameter int unsigned addr_width  = 5,
    parameter int unsigned data_width  = 16,
    parameter int unsigned depth       = 24,
    parameter int unsigned wait_cycles = 1
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [addr_width-1:0]   paddr,
    input  logic [data_width-1:0]   pwdata,
    input  logic [data_width/8-1:0] pstrb,
    output logic [data_width-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int unsigned strb_width = data_width / 8;
    localparam int unsigned cnt_width  = 4;

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_wait = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    // Parameter sanity, caught at elaboration.
    if (wait_cycles > 15) begin : g_bad_wait
        $error("apb_mem_slave: wait_cycles must be in 0..15");
    end
    if ((data_width % 8) != 0 || data_width == 0) begin : g_bad_width
        $error("apb_mem_slave: data_width must be a non-zero multiple of 8");
    end
    if (depth == 0 || depth > (1 << addr_width)) begin : g_bad_depth
        $error("apb_mem_slave: depth must be in 1..2**addr_width");
    end

    logic [1:0]            state_q, state_d;
    logic [cnt_width-1:0]  cnt_q, cnt_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic                  write_q, write_d;

    logic [data_width-1:0] mem [depth];

    logic [addr_width-1:0] xfer_addr_c;
    logic                  xfer_write_c;
    logic                  in_range_c;
    logic                  do_write_c;
    logic [data_width-1:0] rdata_c;

    // Next-state logic: setup latches the request, WAIT counts down, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        case (state_q)
            st_idle: begin
                if (psel && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    cnt_d   = cnt_width'(wait_cycles);
                    state_d = (wait_cycles == 0) ? st_done : st_wait;
                end
            end
            st_wait: begin
                if (!psel) begin
                    state_d = st_idle;
                end else if (penable) begin
                    cnt_d = cnt_q - cnt_width'(1);
                    if (cnt_q == cnt_width'(1)) begin
                        state_d = st_done;
                    end
                end
            end
            st_done: state_d = st_idle;
            default: state_d = st_idle;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= st_idle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    // With zero wait states the response is registered on the setup edge, before addr_q holds it.
    assign xfer_addr_c  = (state_q == st_idle) ? paddr  : addr_q;
    assign xfer_write_c = (state_q == st_idle) ? pwrite : write_q;
    assign in_range_c   = 32'(xfer_addr_c) < 32'(depth);
    assign rdata_c      = (in_range_c && !xfer_write_c) ? mem[xfer_addr_c] : '0;
    assign do_write_c   = (state_q == st_done) && psel && penable && write_q && in_range_c;

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int unsigned i = 0; i < depth; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write_c) begin
            for (int unsigned i = 0; i < strb_width; i++) begin
                if (pstrb[i]) begin
                    mem[addr_q][8*i +: 8] <= pwdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            pready <= 1'b0;
            prdata <= '0;
        end else begin
            pready <= (state_d == st_done);
            prdata <= (state_d == st_done) ? rdata_c : '0;
        end
    end

`ifdef APB_MEM_SLAVE_PSLVERR_EN
    logic err_c;

    assign err_c = !in_range_c || (xfer_write_c && (pstrb == '0));

    always_ff @(posedge pclk) begin
        if (preset) begin
            pslverr <= 1'b0;
        end else begin
            pslverr <= (state_d == st_done) && err_c;
        end
    end
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: three instances (0, 1 and 3 wait states) on a shared bus with per-instance psel.
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic [2:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [4:0]  paddr;
    logic [15:0] pwdata;
    logic [1:0]  pstrb;
    logic [15:0] prdata_v [3];
    logic [2:0]  pready_v;
    logic [2:0]  pslverr_v;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic done_stim = 1'b0;

    typedef struct {
        int          dut;
        logic        is_read;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    typedef struct {
        int dut;
        int cyc;
    } quiet_t;

    exp_t   exp_q[$];
    quiet_t quiet_q[$];

    apb_mem_slave #(.addr_width(5), .data_width(16), .depth(24), .wait_cycles(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0])
    );

    apb_mem_slave #(.addr_width(5), .data_width(16), .depth(24), .wait_cycles(1)) u_dut1 (
        .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1])
    );

    apb_mem_slave #(.addr_width(5), .data_width(16), .depth(24), .wait_cycles(3)) u_dut2 (
        .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2])
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    function automatic int wait_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic exp_err(input logic wr, input logic [4:0] a, input logic [1:0] s);
`ifdef APB_MEM_SLAVE_PSLVERR_EN
        return (a >= 5'd24) || (wr && (s == 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    // Setup + access phases; returns at the start of the pready cycle with psel/penable still high.
    task automatic xfer(input int k, input logic wr, input logic [4:0] a, input logic [15:0] d,
                        input logic [1:0] s, input logic [15:0] exp_d);
        exp_t e;
        int w;
        w = wait_of(k);
        @(posedge pclk); #1;
        psel_v    = 3'b000;
        psel_v[k] = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = a;
        pwdata    = wr ? d : 16'h0000;
        pstrb     = wr ? s : 2'b00;
        e.dut     = k;
        e.is_read = !wr;
        e.data    = exp_d;
        e.err     = exp_err(wr, a, s);
        e.cyc     = cyc + 1 + w;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (w) @(posedge pclk);
    endtask

    task automatic idle();
        @(posedge pclk); #1;
        psel_v  = 3'b000;
        penable = 1'b0;
    endtask

    task automatic quiet(input int k, input int c);
        quiet_t q;
        q.dut = k;
        q.cyc = c;
        quiet_q.push_back(q);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    always @(negedge pclk) begin
        exp_t   e;
        quiet_t q;
        while (quiet_q.size() > 0 && quiet_q[0].cyc <= cyc) begin
            q = quiet_q.pop_front();
            chk("quiet_cycle", 32'(q.cyc), 32'(cyc));
            chk("quiet_pready", 32'(pready_v[q.dut]), 32'd0);
            chk("quiet_prdata", 32'(prdata_v[q.dut]), 32'd0);
            chk("quiet_pslverr", 32'(pslverr_v[q.dut]), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            if (pready_v[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_pready", 32'(k), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pready_dut", 32'(k), 32'(e.dut));
                    chk("pready_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pslverr", 32'(pslverr_v[k]), 32'(e.err));
                    if (e.is_read) begin
                        chk("prdata", 32'(prdata_v[k]), 32'(e.data));
                    end
                end
            end
        end
        if (done_stim || cyc > 5000) begin
            chk("stimulus_finished", 32'(done_stim), 32'd1);
            chk("missing_pready", 32'(exp_q.size()), 32'd0);
            chk("missing_quiet", 32'(quiet_q.size()), 32'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        preset  = 1'b1;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b0;
        for (int k = 0; k < 3; k++) quiet(k, cyc);

        // Reset contents, full write, partial strobes, empty strobe.
        xfer(1, 1'b0, 5'd3, 16'h0, 2'b00, 16'h0000);
        xfer(1, 1'b1, 5'd5, 16'hA55A, 2'b11, 16'h0);
        xfer(1, 1'b0, 5'd5, 16'h0, 2'b00, 16'hA55A);
        xfer(1, 1'b1, 5'd7, 16'h1234, 2'b11, 16'h0);
        xfer(1, 1'b1, 5'd7, 16'hFFFF, 2'b10, 16'h0);
        xfer(1, 1'b0, 5'd7, 16'h0, 2'b00, 16'hFF34);
        xfer(1, 1'b1, 5'd7, 16'h0000, 2'b00, 16'h0);
        xfer(1, 1'b0, 5'd7, 16'h0, 2'b00, 16'hFF34);
        xfer(1, 1'b1, 5'd7, 16'h99AB, 2'b01, 16'h0);
        xfer(1, 1'b0, 5'd7, 16'h0, 2'b00, 16'hFFAB);
        idle();

        // Zero wait states, then an abort in the DONE cycle.
        xfer(0, 1'b1, 5'd1, 16'h00C3, 2'b11, 16'h0);
        xfer(0, 1'b0, 5'd1, 16'h0, 2'b00, 16'h00C3);
        @(posedge pclk); #1;
        psel_v  = 3'b001;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 5'd1;
        pwdata  = 16'hBAD0;
        pstrb   = 2'b11;
        exp_q.push_back('{dut: 0, is_read: 1'b0, data: 16'h0, err: 1'b0, cyc: cyc + 1});
        @(posedge pclk); #1;
        psel_v = 3'b000;
        xfer(0, 1'b0, 5'd1, 16'h0, 2'b00, 16'h00C3);

        // Three wait states, last in-range word and first out-of-range word.
        xfer(2, 1'b1, 5'd23, 16'h7E81, 2'b11, 16'h0);
        xfer(2, 1'b0, 5'd23, 16'h0, 2'b00, 16'h7E81);
        xfer(2, 1'b1, 5'd24, 16'h1111, 2'b11, 16'h0);
        xfer(2, 1'b0, 5'd24, 16'h0, 2'b00, 16'h0000);
        idle();

        // Out of range on the one-wait instance.
        xfer(1, 1'b1, 5'd30, 16'hBEEF, 2'b11, 16'h0);
        xfer(1, 1'b0, 5'd30, 16'h0, 2'b00, 16'h0000);

        // Abort in WAIT: psel drops in the first access cycle.
        xfer(1, 1'b1, 5'd2, 16'h1111, 2'b11, 16'h0);
        idle();
        @(posedge pclk); #1;
        psel_v  = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 5'd2;
        pwdata  = 16'hDEAD;
        pstrb   = 2'b11;
        quiet(1, cyc + 1);
        quiet(1, cyc + 2);
        @(posedge pclk); #1;
        psel_v = 3'b000;
        xfer(1, 1'b0, 5'd2, 16'h0, 2'b00, 16'h1111);
        idle();

        // Reset asserted mid-read: no pready where it would have appeared, memory cleared.
        @(posedge pclk); #1;
        psel_v  = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 5'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        quiet(1, cyc + 1);
        @(posedge pclk); #1;
        preset  = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        xfer(1, 1'b0, 5'd5, 16'h0, 2'b00, 16'h0000);
        xfer(2, 1'b0, 5'd23, 16'h0, 2'b00, 16'h0000);
        idle();

        repeat (6) @(posedge pclk);
        #1;
        done_stim = 1'b1;
    end

endmodule
